// File: rtl/uart_rx_packer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : uart_rx_packer                                                  |
// | Purpose  : Packs WORD_BYTES consecutive UART bytes (little-endian) into    |
// |            one word and offers it through a one-entry valid/ready output   |
// |            register. Reports dropped words (overflow) and, optionally,     |
// |            abandoned partial words (inter-byte timeout).                   |
// |                                                                            |
// | Ports    : clk        in   system clock, rising edge                        |
// |            reset      in   asynchronous reset, active low                  |
// |            rx_data    in   received byte, qualified by rx_ready            |
// |            rx_ready   in   one-cycle strobe per received byte              |
// |            word_data  out  assembled word, first byte in [7:0]             |
// |            word_valid out  word_data holds an unconsumed word              |
// |            word_ready in   consumer accepts when word_valid & word_ready   |
// |            byte_count out  bytes held in the current partial word          |
// |            overflow   out  one-cycle pulse, a completed word was dropped   |
// |            timeout    out  one-cycle pulse, a partial word was discarded   |
// |            busy       out  a partial word is being assembled               |
// |                                                                            |
// | Macro    : UART_RX_PACKER_TIMEOUT_EN enables the inter-byte timeout.       |
// |            Without it no counter exists and timeout is tied low.           |
// |                                                                            |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module uart_rx_packer #(
   parameter int WORD_BYTES     = 4,
   parameter int TIMEOUT_CYCLES = 100000
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [7:0]              rx_data,
   input  logic                    rx_ready,
   output logic [8*WORD_BYTES-1:0] word_data,
   output logic                    word_valid,
   input  logic                    word_ready,
   output logic [3:0]              byte_count,
   output logic                    overflow,
   output logic                    timeout,
   output logic                    busy
);

   // Elaboration-time parameter sanity checks.
   generate
      if (WORD_BYTES < 1 || WORD_BYTES > 8) begin : g_bad_word_bytes
         $error("uart_rx_packer: WORD_BYTES must be in 1..8");
      end
      if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout_cycles
         $error("uart_rx_packer: TIMEOUT_CYCLES must be >= 2");
      end
   endgenerate

   localparam logic [0:0] S_IDLE    = 1'b0;
   localparam logic [0:0] S_COLLECT = 1'b1;
   localparam logic [3:0] LAST_LANE = 4'(WORD_BYTES - 1);

   logic [0:0]              state_q, state_d;
   logic [3:0]              byte_count_q, byte_count_d;
   logic [8*WORD_BYTES-1:0] asm_q, asm_d;
   logic [8*WORD_BYTES-1:0] word_data_q, word_data_d;
   logic                    word_valid_q, word_valid_d;
   logic                    overflow_q, overflow_d;

   logic last_byte;   // the byte on rx_data (if any) completes a word
   logic complete;    // a word completes this cycle
   logic load_word;   // the completed word moves into the output register
   logic expire;      // partial word abandoned this cycle

   assign last_byte = (byte_count_q == LAST_LANE);
   assign complete  = rx_ready & last_byte;
   // The output register is free if empty or being drained this same cycle.
   assign load_word = complete & (~word_valid_q | word_ready);

   // ---------------------------------------------------------------------
   // Optional inter-byte timeout
   // ---------------------------------------------------------------------
`ifdef UART_RX_PACKER_TIMEOUT_EN
   localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

   logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
   logic             timeout_q, timeout_d;

   // Counts silent cycles while collecting; an incoming byte always wins
   // over expiry, and the count sits at zero whenever no word is open.
   always_comb begin
      tmo_cnt_d = '0;
      expire    = 1'b0;
      if (state_q == S_COLLECT && !rx_ready) begin
         if (tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            expire = 1'b1;
         end else begin
            tmo_cnt_d = tmo_cnt_q + 1'b1;
         end
      end
      timeout_d = expire;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         tmo_cnt_q <= '0;
         timeout_q <= 1'b0;
      end else begin
         tmo_cnt_q <= tmo_cnt_d;
         timeout_q <= timeout_d;
      end
   end
`else
   assign expire = 1'b0;
`endif

   // ---------------------------------------------------------------------
   // State register
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= S_IDLE;
         byte_count_q <= '0;
         asm_q        <= '0;
         word_data_q  <= '0;
         word_valid_q <= 1'b0;
         overflow_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         byte_count_q <= byte_count_d;
         asm_q        <= asm_d;
         word_data_q  <= word_data_d;
         word_valid_q <= word_valid_d;
         overflow_q   <= overflow_d;
      end
   end

   // ---------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------
   always_comb begin
      state_d      = state_q;
      byte_count_d = byte_count_q;

      if (rx_ready) begin
         if (last_byte) begin
            state_d      = S_IDLE;
            byte_count_d = '0;
         end else begin
            state_d      = S_COLLECT;
            byte_count_d = byte_count_q + 4'd1;
         end
      end else if (expire) begin
         state_d      = S_IDLE;
         byte_count_d = '0;
      end

      // Write the incoming byte into its lane. On completion asm_d is the
      // full word, including the byte arriving this cycle.
      asm_d = asm_q;
      for (int i = 0; i < WORD_BYTES; i++) begin
         if (rx_ready && byte_count_q == 4'(i)) begin
            asm_d[8*i +: 8] = rx_data;
         end
      end

      word_data_d  = load_word ? asm_d : word_data_q;
      if (load_word) begin
         word_valid_d = 1'b1;
      end else if (word_valid_q && word_ready) begin
         word_valid_d = 1'b0;
      end else begin
         word_valid_d = word_valid_q;
      end

      overflow_d = complete & word_valid_q & ~word_ready;
   end

   // ---------------------------------------------------------------------
   // Output logic
   // ---------------------------------------------------------------------
   always_comb begin
      word_data  = word_data_q;
      word_valid = word_valid_q;
      byte_count = byte_count_q;
      overflow   = overflow_q;
      busy       = (state_q == S_COLLECT);
`ifdef UART_RX_PACKER_TIMEOUT_EN
      timeout    = timeout_q;
`else
      timeout    = 1'b0;
`endif
   end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_packer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_uart_rx_packer                                               |
// | Purpose  : Self-checking bench for uart_rx_packer. One instance with       |
// |            WORD_BYTES=4 / TIMEOUT_CYCLES=16 driven from a vector table     |
// |            plus hand sequences; a second WORD_BYTES=1 instance for the     |
// |            single-byte word case. Honours UART_RX_PACKER_TIMEOUT_EN.       |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_uart_rx_packer;

   logic        clk = 1'b0;
   logic        reset;
   logic [7:0]  rx_data;
   logic        rx_ready;
   logic [31:0] word_data;
   logic        word_valid;
   logic        word_ready;
   logic [3:0]  byte_count;
   logic        overflow;
   logic        timeout;
   logic        busy;

   logic [7:0]  rx1_data;
   logic        rx1_ready;
   logic [7:0]  word1_data;
   logic        word1_valid;
   logic        word1_ready;
   logic [3:0]  byte1_count;
   logic        overflow1;
   logic        timeout1;
   logic        busy1;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   uart_rx_packer #(.WORD_BYTES(4), .TIMEOUT_CYCLES(16)) dut (
      .clk(clk), .reset(reset), .rx_data(rx_data), .rx_ready(rx_ready),
      .word_data(word_data), .word_valid(word_valid), .word_ready(word_ready),
      .byte_count(byte_count), .overflow(overflow), .timeout(timeout), .busy(busy)
   );

   uart_rx_packer #(.WORD_BYTES(1)) dut1 (
      .clk(clk), .reset(reset), .rx_data(rx1_data), .rx_ready(rx1_ready),
      .word_data(word1_data), .word_valid(word1_valid), .word_ready(word1_ready),
      .byte_count(byte1_count), .overflow(overflow1), .timeout(timeout1), .busy(busy1)
   );

   typedef struct {
      logic        rdy;   // rx_ready
      logic [7:0]  d;     // rx_data
      logic        wr;    // word_ready
      logic        ev;    // expected word_valid
      logic [31:0] ed;    // expected word_data
      logic [3:0]  ec;    // expected byte_count
      logic        eo;    // expected overflow
   } vec_t;

   vec_t tbl[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] b, input logic wr);
      rx_ready   = 1'b1;
      rx_data    = b;
      word_ready = wr;
      tick();
      rx_ready   = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

   initial begin
      int seen;
      int at;

      // ---------------- vector table ----------------
      // 4 bytes with consumer ready
      tbl.push_back('{1'b1, 8'h11, 1'b1, 1'b0, 32'h0,        4'd1, 1'b0});
      tbl.push_back('{1'b1, 8'h22, 1'b1, 1'b0, 32'h0,        4'd2, 1'b0});
      tbl.push_back('{1'b1, 8'h33, 1'b1, 1'b0, 32'h0,        4'd3, 1'b0});
      tbl.push_back('{1'b1, 8'h44, 1'b1, 1'b1, 32'h44332211, 4'd0, 1'b0});
      tbl.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 32'h44332211, 4'd0, 1'b0});
      // 8 bytes with consumer stalled: second word dropped
      tbl.push_back('{1'b1, 8'h01, 1'b0, 1'b0, 32'h44332211, 4'd1, 1'b0});
      tbl.push_back('{1'b1, 8'h02, 1'b0, 1'b0, 32'h44332211, 4'd2, 1'b0});
      tbl.push_back('{1'b1, 8'h03, 1'b0, 1'b0, 32'h44332211, 4'd3, 1'b0});
      tbl.push_back('{1'b1, 8'h04, 1'b0, 1'b1, 32'h04030201, 4'd0, 1'b0});
      tbl.push_back('{1'b1, 8'h05, 1'b0, 1'b1, 32'h04030201, 4'd1, 1'b0});
      tbl.push_back('{1'b1, 8'h06, 1'b0, 1'b1, 32'h04030201, 4'd2, 1'b0});
      tbl.push_back('{1'b1, 8'h07, 1'b0, 1'b1, 32'h04030201, 4'd3, 1'b0});
      tbl.push_back('{1'b1, 8'h08, 1'b0, 1'b1, 32'h04030201, 4'd0, 1'b1});
      tbl.push_back('{1'b0, 8'h00, 1'b0, 1'b1, 32'h04030201, 4'd0, 1'b0});
      tbl.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 32'h04030201, 4'd0, 1'b0});
      // held word drained in the same cycle a new word completes
      tbl.push_back('{1'b1, 8'hB0, 1'b0, 1'b0, 32'h04030201, 4'd1, 1'b0});
      tbl.push_back('{1'b1, 8'hB1, 1'b0, 1'b0, 32'h04030201, 4'd2, 1'b0});
      tbl.push_back('{1'b1, 8'hB2, 1'b0, 1'b0, 32'h04030201, 4'd3, 1'b0});
      tbl.push_back('{1'b1, 8'hB3, 1'b0, 1'b1, 32'hB3B2B1B0, 4'd0, 1'b0});
      tbl.push_back('{1'b1, 8'hA0, 1'b0, 1'b1, 32'hB3B2B1B0, 4'd1, 1'b0});
      tbl.push_back('{1'b1, 8'hA1, 1'b0, 1'b1, 32'hB3B2B1B0, 4'd2, 1'b0});
      tbl.push_back('{1'b1, 8'hA2, 1'b0, 1'b1, 32'hB3B2B1B0, 4'd3, 1'b0});
      tbl.push_back('{1'b1, 8'hA3, 1'b1, 1'b1, 32'hA3A2A1A0, 4'd0, 1'b0});
      tbl.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 32'hA3A2A1A0, 4'd0, 1'b0});
      tbl.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 32'hA3A2A1A0, 4'd0, 1'b0});

      // ---------------- reset state ----------------
      reset = 1'b0; rx_ready = 1'b0; rx_data = 8'h00; word_ready = 1'b0;
      rx1_ready = 1'b0; rx1_data = 8'h00; word1_ready = 1'b1;
      tick(); tick();
      chk("rst_valid", 64'(word_valid), 64'd0);
      chk("rst_data",  64'(word_data),  64'd0);
      chk("rst_count", 64'(byte_count), 64'd0);
      chk("rst_busy",  64'(busy),       64'd0);
      chk("rst_ovf",   64'(overflow),   64'd0);
      chk("rst_tmo",   64'(timeout),    64'd0);
      #3 reset = 1'b1;
      tick();

      // ---------------- table-driven vectors ----------------
      foreach (tbl[i]) begin
         rx_ready   = tbl[i].rdy;
         rx_data    = tbl[i].d;
         word_ready = tbl[i].wr;
         tick();
         chk($sformatf("v%0d_valid", i), 64'(word_valid), 64'(tbl[i].ev));
         chk($sformatf("v%0d_data", i),  64'(word_data),  64'(tbl[i].ed));
         chk($sformatf("v%0d_count", i), 64'(byte_count), 64'(tbl[i].ec));
         chk($sformatf("v%0d_busy", i),  64'(busy),       64'(tbl[i].ec != 4'd0));
         chk($sformatf("v%0d_ovf", i),   64'(overflow),   64'(tbl[i].eo));
         chk($sformatf("v%0d_tmo", i),   64'(timeout),    64'd0);
      end
      rx_ready = 1'b0;

      // ---------------- reset mid-word with a held word ----------------
      send(8'hC0, 1'b0); send(8'hC1, 1'b0); send(8'hC2, 1'b0); send(8'hC3, 1'b0);
      chk("pre_rst_valid", 64'(word_valid), 64'd1);
      send(8'h01, 1'b0); send(8'h02, 1'b0);
      chk("pre_rst_count", 64'(byte_count), 64'd2);
      reset = 1'b0;
      #1;
      chk("arst_count", 64'(byte_count), 64'd0);
      chk("arst_busy",  64'(busy),       64'd0);
      chk("arst_valid", 64'(word_valid), 64'd0);
      #2 reset = 1'b1;
      tick();
      send(8'hDE, 1'b1); send(8'hAD, 1'b1); send(8'hBE, 1'b1); send(8'hEF, 1'b1);
      chk("post_rst_valid", 64'(word_valid), 64'd1);
      chk("post_rst_data",  64'(word_data),  64'hEFBEADDE);
      tick();
      chk("post_rst_drain", 64'(word_valid), 64'd0);

      // ---------------- inter-byte silence ----------------
      send(8'h55, 1'b1);
      chk("tmo_first_count", 64'(byte_count), 64'd1);
      seen = 0; at = -1;
      for (int i = 1; i <= 20; i++) begin
         tick();
         if (timeout) begin seen++; at = i; end
      end
`ifdef UART_RX_PACKER_TIMEOUT_EN
      chk("tmo_pulses",    64'(seen),       64'd1);
      chk("tmo_cycle",     64'(at),         64'd16);
      chk("tmo_count",     64'(byte_count), 64'd0);
      chk("tmo_busy",      64'(busy),       64'd0);
      send(8'h01, 1'b1); send(8'h02, 1'b1); send(8'h03, 1'b1); send(8'h04, 1'b1);
      chk("tmo_next_valid", 64'(word_valid), 64'd1);
      chk("tmo_next_data",  64'(word_data),  64'h04030201);
      tick();
      // second byte lands exactly on the expiry cycle
      send(8'h55, 1'b1);
      seen = 0;
      for (int i = 1; i <= 15; i++) begin
         tick();
         if (timeout) seen++;
      end
      send(8'h66, 1'b1);
      if (timeout) seen++;
      chk("race_count", 64'(byte_count), 64'd2);
      for (int i = 1; i <= 3; i++) begin
         tick();
         if (timeout) seen++;
      end
      chk("race_no_tmo", 64'(seen), 64'd0);
      send(8'h22, 1'b1); send(8'h33, 1'b1);
      chk("race_valid", 64'(word_valid), 64'd1);
      chk("race_data",  64'(word_data),  64'h33226655);
`else
      chk("notmo_pulses", 64'(seen),       64'd0);
      chk("notmo_count",  64'(byte_count), 64'd1);
      chk("notmo_busy",   64'(busy),       64'd1);
      send(8'h02, 1'b1); send(8'h03, 1'b1); send(8'h04, 1'b1);
      chk("notmo_valid", 64'(word_valid), 64'd1);
      chk("notmo_data",  64'(word_data),  64'h04030255);
`endif
      tick();

      // ---------------- single-byte words, back-to-back ----------------
      rx1_ready = 1'b1; rx1_data = 8'h7E;
      tick();
      chk("wb1_valid0", 64'(word1_valid), 64'd1);
      chk("wb1_data0",  64'(word1_data),  64'h7E);
      chk("wb1_count0", 64'(byte1_count), 64'd0);
      chk("wb1_busy0",  64'(busy1),       64'd0);
      rx1_data = 8'h7F;
      tick();
      rx1_ready = 1'b0;
      chk("wb1_valid1", 64'(word1_valid), 64'd1);
      chk("wb1_data1",  64'(word1_data),  64'h7F);
      chk("wb1_ovf1",   64'(overflow1),   64'd0);
      tick();
      chk("wb1_drain",  64'(word1_valid), 64'd0);
      chk("wb1_tmo",    64'(timeout1),    64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
